dump_sequencer: RTL and testbench

- Controller that sequences the dump phase of a 2D NMR acquisition.
- On a state_start rising edge it runs a programmed number of dump cycles. Each cycle is an ON interval (dump_on asserted) followed by a sustain interval; both are counted in 10 kHz ticks.
- Emits a one-cycle sustain_start pulse at the beginning of each sustain interval, for the downstream sustain timer.
- Sits between the sequencer state machine (state_start) and the dump driver / sustain timer, all in the clk_sys domain.

---
 rtl/dump_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_dump_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dump_sequencer.sv
// dump_sequencer
// Sequences the dump phase of a 2D NMR acquisition. A rising edge on
// state_start latches the cycle/ON/sustain counts and runs that many
// ON + sustain cycles, timed in ticks of the asynchronous 10 kHz reference.
//
// Ports:
//   clk_sys            system clock
//   rst_n              synchronous active-low reset
//   state_start        level enable; rising edge starts a run, low aborts
//   clk_10k            free-running 10 kHz reference (async to clk_sys)
//   dump_cycles        number of ON+sustain cycles (0 = none)
//   dump_on_data       ON length in ticks (0 = skip ON)
//   dump_sustain_data  sustain length in ticks (0 = skip sustain)
//   dump_on            dump switch drive, high during ON
//   sustain_start      one-clk pulse on entry to SUSTAIN
//   busy               high from accepted start until DONE
//   done               one-clk pulse on normal completion
//   cycle_cnt          index of the current cycle
module dump_sequencer #(
  parameter int CNT_W       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             state_start,
  input  logic             clk_10k,
  input  logic [CNT_W-1:0] dump_cycles,
  input  logic [CNT_W-1:0] dump_on_data,
  input  logic [CNT_W-1:0] dump_sustain_data,
  output logic             dump_on,
  output logic             sustain_start,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ARM      = 3'd1;
  localparam logic [2:0] S_ON       = 3'd2;
  localparam logic [2:0] S_SUS      = 3'd3;
  localparam logic [2:0] S_NEXT     = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;
  localparam logic [2:0] S_WAIT_LOW = 3'd6;

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W:0]   CNT_ONE1 = {{CNT_W{1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic                   start_q, start_d;
  logic                   armed_q, armed_d;
  logic [2:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       cyc_q, cyc_d;
  logic [CNT_W-1:0]       on_q, on_d;
  logic [CNT_W-1:0]       sus_q, sus_d;
  logic [CNT_W-1:0]       cycle_cnt_q, cycle_cnt_d;
  logic                   dump_on_q, dump_on_d;
  logic                   sustain_start_q, sustain_start_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic tick;
  logic start_edge;
  logic running;

  assign tick       = sync_q[SYNC_STAGES-1] & ~hist_q;
  // armed_q blocks a level that was already high across reset from
  // looking like a fresh rising edge.
  assign start_edge = state_start & ~start_q & armed_q;
  assign running    = (state_q == S_ARM) || (state_q == S_ON) ||
                      (state_q == S_SUS) || (state_q == S_NEXT);

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], clk_10k};
    hist_d      = sync_q[SYNC_STAGES-1];
    start_d     = state_start;
    armed_d     = armed_q | ~state_start;
    state_d     = state_q;
    cnt_d       = cnt_q;
    cyc_d       = cyc_q;
    on_d        = on_q;
    sus_d       = sus_q;
    cycle_cnt_d = cycle_cnt_q;

    case (state_q)
      S_IDLE: begin
        cycle_cnt_d = '0;
        if (start_edge) begin
          cyc_d = dump_cycles;
          on_d  = dump_on_data;
          sus_d = dump_sustain_data;
          if ((dump_cycles == '0) ||
              ((dump_on_data == '0) && (dump_sustain_data == '0)))
            state_d = S_DONE;
          else
            state_d = S_ARM;
        end
      end
      S_ARM: begin
        if (tick) begin
          if (on_q != '0) begin
            state_d = S_ON;
            cnt_d   = on_q;
          end else begin
            state_d = S_SUS;
            cnt_d   = sus_q;
          end
        end
      end
      S_ON: begin
        if (tick) begin
          // The tick that exits is consumed; the next state starts fresh.
          if (cnt_q <= CNT_ONE) begin
            if (sus_q != '0) begin
              state_d = S_SUS;
              cnt_d   = sus_q;
            end else begin
              state_d = S_NEXT;
            end
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      S_SUS: begin
        if (tick) begin
          if (cnt_q <= CNT_ONE) state_d = S_NEXT;
          else                  cnt_d   = cnt_q - CNT_ONE;
        end
      end
      S_NEXT: begin
        if (({1'b0, cycle_cnt_q} + CNT_ONE1) == {1'b0, cyc_q}) begin
          state_d = S_DONE;
        end else begin
          cycle_cnt_d = cycle_cnt_q + CNT_ONE;
          if (on_q != '0) begin
            state_d = S_ON;
            cnt_d   = on_q;
          end else begin
            state_d = S_SUS;
            cnt_d   = sus_q;
          end
        end
      end
      S_DONE:     state_d = S_WAIT_LOW;
      S_WAIT_LOW: begin
        if (!state_start) begin
          state_d     = S_IDLE;
          cycle_cnt_d = '0;
        end
      end
      default:    state_d = S_IDLE;
    endcase

    // Dropping state_start mid-run abandons the run without a done pulse.
    if (running && !state_start) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      cycle_cnt_d = '0;
    end

    dump_on_d       = (state_d == S_ON);
    sustain_start_d = (state_d == S_SUS) && (state_q != S_SUS);
    busy_d          = (state_d == S_ARM) || (state_d == S_ON) ||
                      (state_d == S_SUS) || (state_d == S_NEXT);
    done_d          = (state_d == S_DONE) && (state_q != S_DONE);
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      sync_q          <= '0;
      hist_q          <= 1'b0;
      start_q         <= 1'b0;
      armed_q         <= ~state_start;
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      cyc_q           <= '0;
      on_q            <= '0;
      sus_q           <= '0;
      cycle_cnt_q     <= '0;
      dump_on_q       <= 1'b0;
      sustain_start_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      sync_q          <= sync_d;
      hist_q          <= hist_d;
      start_q         <= start_d;
      armed_q         <= armed_d;
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      cyc_q           <= cyc_d;
      on_q            <= on_d;
      sus_q           <= sus_d;
      cycle_cnt_q     <= cycle_cnt_d;
      dump_on_q       <= dump_on_d;
      sustain_start_q <= sustain_start_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

  assign dump_on       = dump_on_q;
  assign sustain_start = sustain_start_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign cycle_cnt     = cycle_cnt_q;

endmodule

// File: tb/tb_dump_sequencer.sv
// tb_dump_sequencer
// Scoreboard bench for dump_sequencer. clk_10k is scaled to a 400 ns
// period so runs stay short; every output event is stamped with the number
// of raw clk_10k rising edges since the run started.
module tb_dump_sequencer;
  localparam int CNT_W = 4;

  logic             clk_sys = 1'b0;
  logic             rst_n = 1'b0;
  logic             state_start = 1'b0;
  logic             clk_10k = 1'b0;
  logic [CNT_W-1:0] dump_cycles = '0;
  logic [CNT_W-1:0] dump_on_data = '0;
  logic [CNT_W-1:0] dump_sustain_data = '0;
  logic             dump_on, sustain_start, busy, done;
  logic [CNT_W-1:0] cycle_cnt;

  int errors = 0;
  int checks = 0;
  int raw_ticks = 0;
  int run_base = 0;

  // kind: 0 = dump_on rise, 1 = dump_on fall, 2 = sustain_start, 3 = done
  typedef struct {
    int kind;
    int tick;
    int cyc;
    int bsy;
  } ev_t;
  ev_t exp_q[$];

  dump_sequencer #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .state_start(state_start),
    .clk_10k(clk_10k), .dump_cycles(dump_cycles), .dump_on_data(dump_on_data),
    .dump_sustain_data(dump_sustain_data), .dump_on(dump_on),
    .sustain_start(sustain_start), .busy(busy), .done(done),
    .cycle_cnt(cycle_cnt)
  );

  always #5 clk_sys = ~clk_sys;
  always #200 clk_10k = ~clk_10k;
  always @(posedge clk_10k) raw_ticks <= raw_ticks + 1;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, expv);
    end
  endtask

  // Reference model: the event timeline of a full run, in ticks.
  task automatic push_run(input int c, input int o, input int s);
    int t;
    if (c == 0 || (o == 0 && s == 0)) begin
      exp_q.push_back('{3, 0, 0, 0});
    end else begin
      t = 1;
      for (int i = 0; i < c; i++) begin
        if (o > 0) begin
          exp_q.push_back('{0, t, i, 1});
          t += o;
          exp_q.push_back('{1, t, i, 1});
        end
        if (s > 0) begin
          exp_q.push_back('{2, t, i, 1});
          t += s;
        end
      end
      exp_q.push_back('{3, t, c - 1, 0});
    end
  endtask

  task automatic handle(input int k);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got event kind %0d at tick %0d, required none",
               k, raw_ticks - run_base);
    end else begin
      e = exp_q.pop_front();
      check("ev_kind", k, e.kind);
      check("ev_tick", raw_ticks - run_base, e.tick);
      check("ev_cycle_cnt", int'(cycle_cnt), e.cyc);
      check("ev_busy", int'(busy), e.bsy);
    end
  endtask

  logic prev_on = 1'b0;
  always @(negedge clk_sys) begin
    if (!rst_n) begin
      prev_on = 1'b0;
    end else begin
      if (prev_on && !dump_on) handle(1);
      if (sustain_start)       handle(2);
      if (!prev_on && dump_on) handle(0);
      if (done)                handle(3);
      prev_on = dump_on;
    end
  end

  // Start a run well clear of the 10 kHz edges so the first tick is
  // always raw edge number 1 after the start.
  task automatic launch(input int c, input int o, input int s);
    dump_cycles       = CNT_W'(c);
    dump_on_data      = CNT_W'(o);
    dump_sustain_data = CNT_W'(s);
    @(posedge clk_10k);
    repeat (6) @(posedge clk_sys);
    #1;
    run_base    = raw_ticks;
    state_start = 1'b1;
  endtask

  task automatic wait_drain(input int budget);
    for (int n = 0; n < budget && exp_q.size() != 0; n++) begin
      @(posedge clk_sys);
      #1;
      // Config inputs wander mid-run; the latched values must govern.
      if ($urandom_range(0, 15) == 0) begin
        dump_cycles       = CNT_W'($urandom_range(0, 15));
        dump_on_data      = CNT_W'($urandom_range(0, 15));
        dump_sustain_data = CNT_W'($urandom_range(0, 15));
      end
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: %0d events pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_run(input int c, input int o, input int s, input int hold);
    launch(c, o, s);
    push_run(c, o, s);
    wait_drain(6000);
    repeat (3) @(posedge clk_sys);
    #1;
    check("busy_after_done", int'(busy), 0);
    repeat (hold) @(posedge clk_sys);
    #1;
    state_start = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    check("cycle_cnt_idle", int'(cycle_cnt), 0);
    check("queue_empty_idle", exp_q.size(), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (4) @(posedge clk_sys);
    #1;
    rst_n = 1'b1;
    #1;
    check("rst_dump_on", int'(dump_on), 0);
    check("rst_sustain_start", int'(sustain_start), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_cycle_cnt", int'(cycle_cnt), 0);

    // Normal run, then level-hold for 20 ticks with no retrigger.
    do_run(2, 3, 6, 800);
    do_run(0, 3, 6, 5);
    do_run(3, 0, 4, 5);
    do_run(3, 2, 0, 5);
    do_run(2, 0, 0, 5);

    // Abort partway into the first ON interval.
    launch(2, 3, 6);
    exp_q.push_back('{0, 1, 0, 1});
    exp_q.push_back('{1, 2, 0, 0});
    n = 0;
    while (raw_ticks < run_base + 2 && n < 200) begin
      @(posedge clk_sys);
      n++;
    end
    check("abort_tick_wait", int'(raw_ticks >= run_base + 2), 1);
    repeat (20) @(posedge clk_sys);
    #1;
    state_start = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;
    check("abort_dump_on", int'(dump_on), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_cycle_cnt", int'(cycle_cnt), 0);
    repeat (300) @(posedge clk_sys);
    #1;
    check("abort_queue", exp_q.size(), 0);
    exp_q.delete();
    do_run(1, 2, 2, 5);

    // Reset in the middle of a sustain interval with state_start held.
    launch(2, 2, 4);
    push_run(2, 2, 4);
    n = 0;
    while (!sustain_start && n < 500) begin
      @(posedge clk_sys);
      #1;
      n++;
    end
    check("sus_seen_before_reset", int'(sustain_start), 1);
    repeat (5) @(posedge clk_sys);
    #1;
    rst_n = 1'b0;
    @(posedge clk_sys);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    check("mrst_dump_on", int'(dump_on), 0);
    check("mrst_sustain_start", int'(sustain_start), 0);
    check("mrst_busy", int'(busy), 0);
    check("mrst_done", int'(done), 0);
    check("mrst_cycle_cnt", int'(cycle_cnt), 0);
    repeat (400) @(posedge clk_sys);
    #1;
    check("mrst_no_restart", int'(busy), 0);
    state_start = 1'b0;
    repeat (3) @(posedge clk_sys);
    do_run(2, 1, 3, 5);

    for (int r = 0; r < 12; r++)
      do_run($urandom_range(0, 3), $urandom_range(0, 4),
             $urandom_range(0, 4), $urandom_range(0, 50));

    repeat (10) @(posedge clk_sys);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
